// File: rtl/axis_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : axis_adc_pkg
//  Brief   : Shared constants and helpers for the ADC stream datapath
//            (sample field placement, accumulator sizing, register map).
//  Rev     : 1.0  initial release
// ============================================================================
package axis_adc_pkg;

    // Conversion word layout: signed sample MSB-aligned in the stream word
    localparam int ADC_DATA_WIDTH   = 32;
    localparam int ADC_SAMPLE_WIDTH = 24;
    localparam int ADC_MAX_LOG2_AVG = 8;

    // Register map shared with the SPI ADC front end
    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_AVG_CFG   = 8'h08;
    localparam logic [7:0] REG_BLOCK_LEN = 8'h0C;
    localparam logic [7:0] REG_OVERRUN   = 8'h10;
    localparam int         CTRL_EN_BIT   = 0;

    // Bit index of the sample LSB within the stream word
    function automatic int sample_lsb(input int data_width, input int sample_width);
        return data_width - sample_width;
    endfunction

    // Accumulator wide enough for 2^max_log2 full-scale samples
    function automatic int acc_width(input int sample_width, input int max_log2);
        return sample_width + max_log2;
    endfunction

    // Clamp a requested log2 averaging ratio to the supported maximum
    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input int max_log2);
        return (int'(req) > max_log2) ? 4'(max_log2) : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
//  Module  : axis_out_reg
//  Brief   : Single-entry AXI Stream output holding register. A new result
//            loads when the register is empty or draining; otherwise it is
//            dropped and a saturating overrun counter advances.
//  Rev     : 1.0  initial release
// ============================================================================
module axis_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             loaded,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [15:0]      overrun_count
);

    localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

    logic drain;
    logic drop;

    assign drain  = m_axis_tvalid & m_axis_tready;
    assign loaded = load & (~m_axis_tvalid | m_axis_tready);
    assign drop   = load & m_axis_tvalid & ~m_axis_tready;

    // Holding register: load a new result, or release the held one on handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (loaded) begin
            m_axis_tdata  <= load_data;
            m_axis_tlast  <= load_last;
            m_axis_tvalid <= 1'b1;
        end else if (drain) begin
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end
    end

    // Saturating count of results that found the output stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun_count <= '0;
        end else if (drop && (overrun_count != OVERRUN_MAX)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_adc_averager.sv
`default_nettype none
// ============================================================================
//  Module  : axis_adc_averager
//  Brief   : Boxcar decimating averager for the ADC conversion stream.
//            Averages 2^L signed samples, emits one sign-extended result per
//            window with TLAST every cfg_block_len outputs. The input side is
//            never back-pressured; results meeting a stalled output are dropped.
//  Rev     : 1.0  initial release
// ============================================================================
module axis_adc_averager
    import axis_adc_pkg::*;
#(
    parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
    parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
    parameter int MAX_LOG2_AVG = ADC_MAX_LOG2_AVG
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  en,
    input  logic [3:0]            cfg_log2_avg,
    input  logic [15:0]           cfg_block_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           overrun_count
);

    localparam int ACC_W  = acc_width(SAMPLE_WIDTH, MAX_LOG2_AVG);
    localparam int CNT_W  = MAX_LOG2_AVG + 1;
    localparam int SMP_LSB = sample_lsb(DATA_WIDTH, SAMPLE_WIDTH);

    // Window state
    logic                    ready_q;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic [3:0]              ratio;

    // Frame state
    logic [15:0]             frame_cnt;
    logic [15:0]             len_q;

    // Datapath wires
    logic                           accept;
    logic [3:0]                     eff_l;
    logic [CNT_W-1:0]               last_idx;
    logic                           complete;
    logic signed [SAMPLE_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]        sample_ext;
    logic signed [ACC_W-1:0]        sum_next;
    logic signed [ACC_W-1:0]        shifted;
    logic signed [SAMPLE_WIDTH-1:0] avg_sample;
    logic [DATA_WIDTH-1:0]          result;
    logic [15:0]                    eff_len;
    logic                           res_last;
    logic                           loaded;

    // Low word bits carry no sample information
    generate
        if (SMP_LSB > 0) begin : g_unused_low
            logic unused_low_bits;
            assign unused_low_bits = ^s_axis_tdata[SMP_LSB-1:0];
        end
    endgenerate

    assign s_axis_tready = ready_q;
    assign accept        = s_axis_tvalid & ready_q & en;

    // The ratio is sampled from config only at a window start
    assign eff_l      = (count == '0) ? clamp_log2(cfg_log2_avg, MAX_LOG2_AVG) : ratio;
    assign last_idx   = (CNT_W'(1) << eff_l) - CNT_W'(1);
    assign complete   = accept & (count == last_idx);

    assign sample     = s_axis_tdata[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign sample_ext = ACC_W'(sample);
    assign sum_next   = (count == '0) ? sample_ext : (acc + sample_ext);
    assign shifted    = sum_next >>> eff_l;
    assign avg_sample = shifted[SAMPLE_WIDTH-1:0];
    assign result     = DATA_WIDTH'(avg_sample);

    // Block length is sampled from config only at a frame start
    assign eff_len  = (frame_cnt == 16'd0) ? cfg_block_len : len_q;
    assign res_last = (eff_len != 16'd0) && (frame_cnt == (eff_len - 16'd1));

    // Input ready rises on the first clock after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Accumulate samples into the current window; disable discards the window
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc   <= '0;
            count <= '0;
            ratio <= '0;
        end else if (!en) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (count == '0) begin
                ratio <= eff_l;
            end
            acc   <= sum_next;
            count <= complete ? '0 : (count + CNT_W'(1));
        end
    end

    // Count loaded results toward TLAST; dropped results do not advance the frame
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
            len_q     <= '0;
        end else if (!en) begin
            frame_cnt <= '0;
        end else if (loaded) begin
            if (frame_cnt == 16'd0) begin
                len_q <= cfg_block_len;
            end
            if ((eff_len == 16'd0) || res_last) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    axis_out_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (complete),
        .load_data     (result),
        .load_last     (res_last),
        .loaded        (loaded),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overrun_count (overrun_count)
    );

endmodule
`default_nettype wire
